// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   state_t     : controller states (IDLE, ADD, DONE)
//   NIBBLE_W    : width of the carry look-ahead slice
//   nibbles_of  : number of ADD cycles needed for a given operand width
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  function automatic int nibbles_of(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand / result bus of the nibble-serial adder.
//   Operand side : in_valid, in_ready, A, B, Cin
//   Result side  : out_valid, out_ready, Sum, Carry_Out
//   Status       : busy (high while an operation is in flight or waiting)
//
// Handshake rule, both sides: a transfer happens on a rising clock edge where
// valid and ready are both high. The producer holds its payload stable while
// valid is high and ready is low; valid never depends combinationally on ready.
//
// Modports: slave = the adder itself, master = whatever drives operands and
// consumes results.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Carry_Out;
  logic             busy;

  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, Sum, Carry_Out, busy
  );

  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, Sum, Carry_Out, busy
  );
endinterface

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Purely combinational 4-bit carry look-ahead adder.
//   a, b : nibble operands
//   cin  : carry in
//   s    : nibble sum
//   c4   : carry out
// Every carry is written in flattened generate/propagate form so none of them
// waits on a lower carry.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c4
);
  logic [3:0] g;
  logic [3:0] p;
  logic       c1, c2, c3;

  assign g = a & b;
  assign p = a ^ b;

  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & cin);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ {c3, c2, c1, cin};
endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a single 4-bit
// carry look-ahead slice, carry registered between nibbles.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : operand/result handshake bus (slave side)
//   state_dbg : current controller state, for observation only
// Latency from accept edge to out_valid is WIDTH/4 cycles; the result is held
// until the consumer takes it.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_adder_if.slave bus,
  output state_t               state_dbg
);
  localparam int NIBBLES = nibbles_of(WIDTH);
  // One extra count value so the counter is at least one bit wide at WIDTH=4.
  localparam int CNT_W = $clog2(NIBBLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_next;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       slice_s;
  logic             slice_c;
  logic             accept;
  logic             retire;

  cla4_slice u_slice (
    .a   (a_q[NIBBLE_W-1:0]),
    .b   (b_q[NIBBLE_W-1:0]),
    .cin (carry_q),
    .s   (slice_s),
    .c4  (slice_c)
  );

  // While rst is high the flops are held anyway, so accept need not see rst.
  assign accept = (state_q == IDLE) && bus.in_valid;
  assign retire = (state_q == DONE) && bus.out_ready;

  // New nibble enters at the top; after NIBBLES shifts nibble 0 sits at the
  // bottom. Written as shift/or so it also holds when WIDTH == NIBBLE_W.
  assign sum_next = (sum_q >> NIBBLE_W)
                  | (WIDTH'(slice_s) << (WIDTH - NIBBLE_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ADD;
      ADD:     if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (retire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            carry_q <= bus.Cin;
            cnt_q   <= '0;
          end
        end
        ADD: begin
          a_q     <= a_q >> NIBBLE_W;
          b_q     <= b_q >> NIBBLE_W;
          sum_q   <= sum_next;
          carry_q <= slice_c;
          cnt_q   <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // All handshake outputs decode registered state only.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.Sum       = sum_q;
  assign bus.Carry_Out = carry_q;
  assign state_dbg     = state_q;
endmodule
